shot_control: RTL and testbench

- Parametrised projectile manager for the laser-paddle power-up. Owns SHOT_NUM independent shots, spawns them at the paddle on a fire pulse and moves them upward on a divided tick.
- On each tick it queries and damages the brick grid through the existing block-memory request/ready port.
- Sits beside state_control. Drives draw_ball (shot instance) via packed s_x/s_y/s_active, and shares block_memory through an external arbiter.

---
 rtl/shot_control.sv | 216 +++++++++++++++++++++
 tb/tb_shot_control.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_control.sv
// rtl/shot_control.sv - laser-paddle shot manager; optional piercing shots under SHOT_PIERCE_EN
module shot_control #(
    parameter int SHOT_NUM  = 2,
    parameter int COORD_W   = 10,
    parameter int TICK_DIV  = 250000,
    parameter int SPEED     = 4,
    parameter int TOP_Y     = 16,
    parameter int SPAWN_OFS = 8,
    parameter int COOLDOWN  = 10,
    parameter int GRID_X0   = 0,
    parameter int GRID_Y0   = 32,
    parameter int BW_LOG2   = 5,
    parameter int BH_LOG2   = 4,
    parameter int ROWS      = 12,
    parameter int COLS      = 20
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        fire,
`ifdef SHOT_PIERCE_EN
    input  logic                        pierce,
`endif
    input  logic [COORD_W-1:0]          p_x,
    input  logic [COORD_W-1:0]          p_y,
    input  logic                        bm_ready,
    input  logic [3:0]                  bm_block,
    output logic                        bm_enable,
    output logic [4:0]                  bm_row,
    output logic [4:0]                  bm_col,
    output logic [1:0]                  bm_func,
    output logic [SHOT_NUM*COORD_W-1:0] s_x,
    output logic [SHOT_NUM*COORD_W-1:0] s_y,
    output logic [SHOT_NUM-1:0]         s_active,
    output logic                        hit,
    output logic                        fire_drop,
    output logic                        busy
);
    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int IW  = (SHOT_NUM > 1) ? $clog2(SHOT_NUM) : 1;
    localparam logic [COORD_W:0] X0 = (COORD_W+1)'(GRID_X0);
    localparam logic [COORD_W:0] Y0 = (COORD_W+1)'(GRID_Y0);

    typedef enum logic [2:0] {IDLE, MOVE, SCAN, QREQ, QWAIT, HREQ, HWAIT} state_t;
    state_t state, state_n;

    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [CDW-1:0]     cool;
    logic [IW-1:0]      idx, idx_n;
    logic [COORD_W-1:0] x_r [SHOT_NUM];
    logic [COORD_W-1:0] y_r [SHOT_NUM];
    logic [SHOT_NUM-1:0] act;
    logic               any_free;
    logic [IW-1:0]      free_idx;
    logic               fire_ok;
    logic [COORD_W:0]   dx, dy;
    logic [COORD_W-1:0] row_full, col_full;
    logic               outside;
    logic               last;
    logic               hit_retire;

    assign tick    = enable && (tick_cnt == TW'(TICK_DIV - 1));
    assign last    = (idx == IW'(SHOT_NUM - 1));
    assign fire_ok = fire && enable && (cool == '0) && any_free;

`ifdef SHOT_PIERCE_EN
    logic [SHOT_NUM-1:0] prc;
    assign hit_retire = !prc[idx];
`else
    assign hit_retire = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt <= '0;
            cool     <= '0;
        end else begin
            if (enable)
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (fire_ok)
                cool <= CDW'(COOLDOWN);
            else if (tick && cool != '0)
                cool <= cool - 1'b1;
        end
    end

    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int k = SHOT_NUM - 1; k >= 0; k--) begin
            if (!act[k]) begin
                any_free = 1'b1;
                free_idx = IW'(k);
            end
        end
    end

    // Borrow out of the origin subtraction flags a coordinate left of / above the grid
    always_comb begin
        dx       = {1'b0, x_r[idx]} - X0;
        dy       = {1'b0, y_r[idx]} - Y0;
        col_full = dx[COORD_W-1:0] >> BW_LOG2;
        row_full = dy[COORD_W-1:0] >> BH_LOG2;
        outside  = dx[COORD_W] || dy[COORD_W] ||
                   (row_full >= COORD_W'(ROWS)) || (col_full >= COORD_W'(COLS));
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        unique case (state)
            IDLE:  if (tick) state_n = MOVE;
            MOVE: begin
                state_n = SCAN;
                idx_n   = '0;
            end
            SCAN: begin
                if (act[idx] && !outside) state_n = QREQ;
                else if (last)            state_n = IDLE;
                else                      idx_n   = idx + 1'b1;
            end
            QREQ:  state_n = QWAIT;
            QWAIT: begin
                if (bm_ready) begin
                    if (bm_block != 4'd0) state_n = HREQ;
                    else if (last)        state_n = IDLE;
                    else begin
                        state_n = SCAN;
                        idx_n   = idx + 1'b1;
                    end
                end
            end
            HREQ:  state_n = HWAIT;
            HWAIT: begin
                if (bm_ready) begin
                    if (last) state_n = IDLE;
                    else begin
                        state_n = SCAN;
                        idx_n   = idx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            bm_row <= '0;
            bm_col <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (state == SCAN && state_n == QREQ) begin
                bm_row <= row_full[4:0];
                bm_col <= col_full[4:0];
            end
        end
    end

    // Later assignments win: a spawn overrides move/retire for its slot
    always_ff @(posedge clock) begin
        if (reset) begin
            act       <= '0;
            fire_drop <= 1'b0;
            for (int k = 0; k < SHOT_NUM; k++) begin
                x_r[k] <= '0;
                y_r[k] <= '0;
            end
`ifdef SHOT_PIERCE_EN
            prc <= '0;
`endif
        end else begin
            fire_drop <= fire && enable && (cool == '0) && !any_free;
            if (state == MOVE) begin
                for (int k = 0; k < SHOT_NUM; k++) begin
                    if (act[k]) begin
                        if (y_r[k] >= COORD_W'(TOP_Y + SPEED))
                            y_r[k] <= y_r[k] - COORD_W'(SPEED);
                        else
                            act[k] <= 1'b0;
                    end
                end
            end
            if (state == HWAIT && bm_ready && hit_retire)
                act[idx] <= 1'b0;
            if (fire_ok) begin
                x_r[free_idx] <= p_x;
                y_r[free_idx] <= p_y - COORD_W'(SPAWN_OFS);
                act[free_idx] <= 1'b1;
`ifdef SHOT_PIERCE_EN
                prc[free_idx] <= pierce;
`endif
            end
        end
    end

    always_comb begin
        s_x = '0;
        s_y = '0;
        for (int k = 0; k < SHOT_NUM; k++) begin
            s_x[k*COORD_W +: COORD_W] = x_r[k];
            s_y[k*COORD_W +: COORD_W] = y_r[k];
        end
    end

    assign s_active  = act;
    assign bm_enable = (state == QREQ) || (state == HREQ);
    assign bm_func   = (state == HREQ || state == HWAIT) ? 2'b01 : 2'b00;
    assign hit       = (state == HREQ);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_shot_control.sv
// tb/tb_shot_control.sv - vector table, directed sequences and randomized model check for shot_control
module tb_shot_control;
    localparam int SN = 2;
    localparam int CW = 10;
    localparam int TD = 64;
    localparam int CD = 2;

    logic clock = 1'b0;
    logic reset, enable, fire;
`ifdef SHOT_PIERCE_EN
    logic pierce;
`endif
    logic [CW-1:0] p_x, p_y;
    logic bm_ready;
    logic [3:0] bm_block;
    logic bm_enable;
    logic [4:0] bm_row, bm_col;
    logic [1:0] bm_func;
    logic [SN*CW-1:0] s_x, s_y;
    logic [SN-1:0] s_active;
    logic hit, fire_drop, busy;

    shot_control #(.SHOT_NUM(SN), .COORD_W(CW), .TICK_DIV(TD), .COOLDOWN(CD)) dut (
        .clock(clock), .reset(reset), .enable(enable), .fire(fire),
`ifdef SHOT_PIERCE_EN
        .pierce(pierce),
`endif
        .p_x(p_x), .p_y(p_y), .bm_ready(bm_ready), .bm_block(bm_block),
        .bm_enable(bm_enable), .bm_row(bm_row), .bm_col(bm_col), .bm_func(bm_func),
        .s_x(s_x), .s_y(s_y), .s_active(s_active),
        .hit(hit), .fire_drop(fire_drop), .busy(busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int ec = 0;
    bit tick_now = 1'b0;
    int fixed_delay = -1;
    bit chk_stab = 1'b0;
    int stab_bad = 0;
    int hit_cnt = 0;
    logic [11:0] req_log [$];
    logic [3:0] mem_grid [32][32];
    logic [3:0] ref_grid [32][32];

    always @(negedge clock) if (hit === 1'b1) hit_cnt++;

    // Block memory stand-in: answers each strobe after a delay, clears the cell on a hit
    initial begin : responder
        logic [1:0] f;
        logic [4:0] r, c;
        int d;
        bm_ready = 1'b0;
        bm_block = 4'd0;
        forever begin
            @(negedge clock);
            bm_ready = 1'b0;
            if (bm_enable === 1'b1) begin
                f = bm_func; r = bm_row; c = bm_col;
                req_log.push_back({f, r, c});
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                for (int i = 0; i <= d; i++) begin
                    @(negedge clock);
                    if (chk_stab && (bm_row !== r || bm_col !== c)) stab_bad++;
                end
                bm_block = mem_grid[r][c];
                if (f == 2'b01) mem_grid[r][c] = 4'd0;
                bm_ready = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        tick_now = !reset && enable && (ec % TD == TD - 1);
        if (reset) ec = 0;
        else if (enable) ec++;
        #1;
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 4000 && ec < target; n++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; fire = 1'b0; p_x = '0; p_y = '0;
`ifdef SHOT_PIERCE_EN
        pierce = 1'b0;
`endif
        step(); step();
        reset = 1'b0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                mem_grid[r][c] = 4'd0;
                ref_grid[r][c] = 4'd0;
            end
    endtask

    task automatic fire_at(input int x, input int y);
        fire = 1'b1; p_x = CW'(x); p_y = CW'(y);
        step();
        fire = 1'b0;
    endtask

    function automatic logic [11:0] req(input int f, input int r, input int c);
        return {2'(f), 5'(r), 5'(c)};
    endfunction

    typedef struct {
        int px; int py; int blk;
        bit rd; int row; int col; bit hx; bit act; int y;
    } vec_t;
    vec_t vt [9];

    // Reference model state (spec-level arithmetic)
    bit m_act [SN];
    int m_x [SN];
    int m_y [SN];
    int m_cool;
    logic [11:0] exp_q [$];
    int exp_hits;

    task automatic model_tick();
        int r, c;
        if (m_cool > 0) m_cool--;
        exp_q.delete();
        exp_hits = 0;
        for (int k = 0; k < SN; k++)
            if (m_act[k]) begin
                if (m_y[k] >= 16 + 4) m_y[k] -= 4;
                else m_act[k] = 1'b0;
            end
        for (int k = 0; k < SN; k++)
            if (m_act[k] && m_y[k] >= 32) begin
                r = (m_y[k] - 32) / 16;
                c = m_x[k] / 32;
                if (r < 12 && c < 20) begin
                    exp_q.push_back(req(0, r, c));
                    if (ref_grid[r][c] != 4'd0) begin
                        exp_q.push_back(req(1, r, c));
                        exp_hits++;
                        ref_grid[r][c] = 4'd0;
                        m_act[k] = 1'b0;
                    end
                end
            end
    endtask

    function automatic logic [SN-1:0] m_packed();
        logic [SN-1:0] v;
        for (int k = 0; k < SN; k++) v[k] = m_act[k];
        return v;
    endfunction

    initial begin
        int base, h0, n0, s0, fk, px, py, ph;
        bit pending, exp_drop;

        vt[0] = '{100, 72, 3, 1, 1, 3, 1, 0, 0};
        vt[1] = '{100, 72, 0, 1, 1, 3, 0, 1, 60};
        vt[2] = '{639, 235, 5, 1, 11, 19, 1, 0, 0};
        vt[3] = '{640, 235, 5, 0, 0, 0, 0, 1, 223};
        vt[4] = '{100, 236, 5, 0, 0, 0, 0, 1, 224};
        vt[5] = '{100, 44, 1, 1, 0, 3, 1, 0, 0};
        vt[6] = '{100, 43, 1, 0, 0, 0, 0, 1, 31};
        vt[7] = '{5, 28, 0, 0, 0, 0, 0, 1, 16};
        vt[8] = '{5, 27, 0, 0, 0, 0, 0, 0, 0};

        // Reset state and first spawn
        do_reset();
        check("rst_active", s_active, 0);
        check("rst_sx", s_x, 0);
        check("rst_sy", s_y, 0);
        check("rst_bm", {bm_enable, bm_row, bm_col, bm_func}, 0);
        check("rst_flags", {hit, fire_drop, busy}, 0);
        base = req_log.size();
        fire_at(320, 440);
        check("spawn_active", s_active, 2'b01);
        check("spawn_x", s_x[9:0], 320);
        check("spawn_y", s_y[9:0], 432);
        check("spawn_busy", busy, 0);
        fire_at(200, 440);
        check("cool_ignore_active", s_active, 2'b01);
        check("cool_ignore_drop", fire_drop, 0);
        run_to(TD + 40);
        fire_at(200, 440);
        check("cool_ignore2_active", s_active, 2'b01);
        run_to(2 * TD + 40);
        fire_at(200, 300);
        check("fire2_active", s_active, 2'b11);
        check("fire2_x", s_x[19:10], 200);
        check("fire2_y", s_y[19:10], 292);
        run_to(4 * TD + 40);
        fire_at(50, 400);
        check("full_drop", fire_drop, 1);
        check("full_active", s_active, 2'b11);
        check("full_x", s_x, {10'd200, 10'd320});
        check("full_y", s_y, {10'd284, 10'd416});
        step();
        check("drop_pulse_end", fire_drop, 0);
        check("fire_seq_noreq", req_log.size() - base, 0);

        // Table: single shot, first sweep after spawn
        for (int i = 0; i < 9; i++) begin
            do_reset();
            if (vt[i].rd) mem_grid[vt[i].row][vt[i].col] = 4'(vt[i].blk);
            fire_at(vt[i].px, vt[i].py);
            base = req_log.size();
            h0 = hit_cnt;
            run_to(TD + 40);
            check($sformatf("vec%0d_nreq", i), req_log.size() - base, int'(vt[i].rd) + int'(vt[i].hx));
            if (vt[i].rd && req_log.size() > base)
                check($sformatf("vec%0d_read", i), req_log[base], req(0, vt[i].row, vt[i].col));
            if (vt[i].hx && req_log.size() > base + 1)
                check($sformatf("vec%0d_hitreq", i), req_log[base + 1], req(1, vt[i].row, vt[i].col));
            check($sformatf("vec%0d_hits", i), hit_cnt - h0, int'(vt[i].hx));
            check($sformatf("vec%0d_act", i), s_active[0], vt[i].act);
            if (vt[i].act) check($sformatf("vec%0d_y", i), s_y[9:0], vt[i].y);
            check($sformatf("vec%0d_busy", i), busy, 0);
        end

        // Retire at the top: y=20 moves to 16, next tick retires without a request
        do_reset();
        fire_at(5, 28);
        base = req_log.size();
        run_to(TD + 40);
        check("top_y16", s_y[9:0], 16);
        run_to(2 * TD + 40);
        check("top_retired", s_active, 0);
        check("top_noreq", req_log.size() - base, 0);

        // Slot 0 reads empty, slot 1 hits; slow memory, address must hold
        do_reset();
        fixed_delay = 5;
        chk_stab = 1'b1;
        s0 = stab_bad;
        fire_at(100, 72);
        run_to(2 * TD + 40);
        fire_at(400, 80);
        mem_grid[2][12] = 4'd7;
        base = req_log.size();
        h0 = hit_cnt;
        run_to(3 * TD + 40);
        check("slow_nreq", req_log.size() - base, 3);
        if (req_log.size() >= base + 3) begin
            check("slow_req0", req_log[base], req(0, 1, 3));
            check("slow_req1", req_log[base + 1], req(0, 2, 12));
            check("slow_req2", req_log[base + 2], req(1, 2, 12));
        end
        check("slow_hits", hit_cnt - h0, 1);
        check("slow_active", s_active, 2'b01);
        check("slow_y0", s_y[9:0], 52);
        check("slow_stable", stab_bad - s0, 0);
        chk_stab = 1'b0;

        // Reset while waiting for the read result; the late ready must be ignored
        do_reset();
        fixed_delay = 8;
        fire_at(100, 72);
        mem_grid[1][3] = 4'd3;
        base = req_log.size();
        h0 = hit_cnt;
        run_to(TD);
        for (int n = 0; n < 10 && req_log.size() == base; n++) step();
        check("qwait_req_seen", req_log.size() - base, 1);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n0 = req_log.size();
        check("qrst_active", s_active, 0);
        check("qrst_sxy", {s_x, s_y}, 0);
        check("qrst_bm", {bm_enable, bm_row, bm_col, bm_func}, 0);
        check("qrst_flags", {hit, fire_drop, busy}, 0);
        repeat (15) step();
        check("qrst_nohit", hit_cnt - h0, 0);
        check("qrst_noreq", req_log.size() - n0, 0);
        check("qrst_idle", {busy, s_active}, 0);
        fixed_delay = -1;

        // enable drop mid-sweep: sweep completes, no further ticks
        do_reset();
        fire_at(100, 72);
        base = req_log.size();
        run_to(TD);
        enable = 1'b0;
        repeat (30) step();
        check("en_sweep_done", busy, 0);
        check("en_sweep_req", req_log.size() - base, 1);
        check("en_sweep_y", s_y[9:0], 60);
        repeat (200) step();
        check("en_frozen_y", s_y[9:0], 60);
        enable = 1'b1;

`ifdef SHOT_PIERCE_EN
        do_reset();
        pierce = 1'b1;
        fire_at(100, 72);
        pierce = 1'b0;
        mem_grid[1][3] = 4'd3;
        h0 = hit_cnt;
        run_to(TD + 40);
        check("pierce_hit", hit_cnt - h0, 1);
        check("pierce_active", s_active[0], 1);
`endif

        // Randomized: random grid and fires, checked against the model
        do_reset();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 20; c++) begin
                mem_grid[r][c] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                ref_grid[r][c] = mem_grid[r][c];
            end
        for (int k = 0; k < SN; k++) begin
            m_act[k] = 1'b0; m_x[k] = 0; m_y[k] = 0;
        end
        m_cool = 0;
        pending = 1'b0;
        base = 0;
        h0 = 0;
        while (ec < 60 * TD) begin
            ph = ec % TD;
            if (ph == 40 && pending) begin
                check("rnd_busy", busy, 0);
                check("rnd_nreq", req_log.size() - base, exp_q.size());
                for (int j = 0; j < exp_q.size() && base + j < req_log.size(); j++)
                    check($sformatf("rnd_req%0d", j), req_log[base + j], exp_q[j]);
                check("rnd_hits", hit_cnt - h0, exp_hits);
                check("rnd_active", s_active, m_packed());
                for (int k = 0; k < SN; k++)
                    if (m_act[k]) begin
                        check($sformatf("rnd_x%0d", k), s_x[k*CW +: CW], m_x[k]);
                        check($sformatf("rnd_y%0d", k), s_y[k*CW +: CW], m_y[k]);
                    end
                pending = 1'b0;
            end
            if (ph == 45 && $urandom_range(0, 1) == 1) begin
                px = $urandom_range(0, 700);
                py = $urandom_range(40, 330);
                exp_drop = 1'b0;
                fk = -1;
                if (m_cool == 0) begin
                    for (int k = SN - 1; k >= 0; k--) if (!m_act[k]) fk = k;
                    if (fk >= 0) begin
                        m_act[fk] = 1'b1; m_x[fk] = px; m_y[fk] = py - 8; m_cool = CD;
                    end else exp_drop = 1'b1;
                end
                fire_at(px, py);
                check("rnd_drop", fire_drop, exp_drop);
                check("rnd_fire_active", s_active, m_packed());
                if (fk >= 0) begin
                    check("rnd_spawn_x", s_x[fk*CW +: CW], m_x[fk]);
                    check("rnd_spawn_y", s_y[fk*CW +: CW], m_y[fk]);
                end
            end else begin
                step();
            end
            if (tick_now) begin
                model_tick();
                base = req_log.size();
                h0 = hit_cnt;
                pending = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
